// File: rtl/ctrl_pkg.sv
// Shared constants for the pipeline control unit: opcodes, bundle field
// offsets, aluop codes and the stage-register record types.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Flag offsets above the aluop field; bundle = {flags, aluop}.
    localparam int unsigned N_FLAGS    = 9;
    localparam int unsigned F_MEMTOREG = 0;
    localparam int unsigned F_MEMWRITE = 1;
    localparam int unsigned F_JALR     = 2;
    localparam int unsigned F_JUMP     = 3;
    localparam int unsigned F_BRANCH   = 4;
    localparam int unsigned F_ASEL_PC  = 5;
    localparam int unsigned F_ALUSRC   = 6;
    localparam int unsigned F_LINK     = 7;
    localparam int unsigned F_REGWRITE = 8;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2,
        ALU_PASSB = 2'd3
    } aluop_e;

    typedef struct packed {
        logic regwrite;
        logic link;
        logic memwrite;
        logic memtoreg;
        logic valid;
    } exmem_t;

    typedef struct packed {
        logic regwrite;
        logic link;
        logic memtoreg;
    } memwb_t;

    function automatic int unsigned ctrl_w(input int unsigned aluop_w);
        return N_FLAGS + aluop_w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode + valid -> control bundle and
// illegal flag. Disabled optional classes decode as illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W  = 2,
    parameter bit          EN_JUMP  = 1'b1,
    parameter bit          EN_UPPER = 1'b1,
    localparam int unsigned CTRL_W  = ctrl_w(ALUOP_W)
) (
    input  logic [6:0]        op_i,
    input  logic              valid_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o
);

    logic [N_FLAGS-1:0] flags;
    aluop_e             aluop;
    logic               legal;

    always_comb begin
        flags = '0;
        aluop = ALU_ADD;
        legal = 1'b1;
        case (op_i)
            OP_R: begin
                flags[F_REGWRITE] = 1'b1;
                aluop             = ALU_FUNCT;
            end
            OP_IALU: begin
                flags[F_REGWRITE] = 1'b1;
                flags[F_ALUSRC]   = 1'b1;
                aluop             = ALU_FUNCT;
            end
            OP_LOAD: begin
                flags[F_REGWRITE] = 1'b1;
                flags[F_ALUSRC]   = 1'b1;
                flags[F_MEMTOREG] = 1'b1;
            end
            OP_STORE: begin
                flags[F_ALUSRC]   = 1'b1;
                flags[F_MEMWRITE] = 1'b1;
            end
            OP_BRANCH: begin
                flags[F_BRANCH] = 1'b1;
                aluop           = ALU_SUB;
            end
            OP_JAL: begin
                if (EN_JUMP) begin
                    flags[F_REGWRITE] = 1'b1;
                    flags[F_LINK]     = 1'b1;
                    flags[F_JUMP]     = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_JALR: begin
                if (EN_JUMP) begin
                    flags[F_REGWRITE] = 1'b1;
                    flags[F_LINK]     = 1'b1;
                    flags[F_JUMP]     = 1'b1;
                    flags[F_JALR]     = 1'b1;
                    flags[F_ALUSRC]   = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_LUI: begin
                if (EN_UPPER) begin
                    flags[F_REGWRITE] = 1'b1;
                    flags[F_ALUSRC]   = 1'b1;
                    aluop             = ALU_PASSB;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_AUIPC: begin
                if (EN_UPPER) begin
                    flags[F_REGWRITE] = 1'b1;
                    flags[F_ALUSRC]   = 1'b1;
                    flags[F_ASEL_PC]  = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        ctrl_o    = (valid_i && legal) ? {flags, ALUOP_W'(aluop)} : '0;
        illegal_o = valid_i & ~legal;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control unit: decodes the ID opcode and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB under hold/flush control.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W  = 2,
    parameter bit          EN_JUMP  = 1'b1,
    parameter bit          EN_UPPER = 1'b1,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned CTRL_W  = ctrl_w(ALUOP_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op_d,
    input  logic              valid_d,
    input  logic              hold_e,
    input  logic              flush_e,
    input  logic              flush_m,
    output logic              illegal_d,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              valid_e,
    output logic              illegal_e,
    output logic              regwrite_m,
    output logic              memwrite_m,
    output logic              memtoreg_m,
    output logic              valid_m,
    output logic              regwrite_w,
    output logic              memtoreg_w,
    output logic              link_w,
    output logic [CNT_W-1:0]  illegal_cnt
);

    logic [CTRL_W-1:0] dec_ctrl;

    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
    logic              valid_e_q, valid_e_d;
    logic              illegal_e_q, illegal_e_d;
    exmem_t            exmem_q, exmem_d;
    memwb_t            memwb_q, memwb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              idex_load;

    ctrl_decode #(
        .ALUOP_W  (ALUOP_W),
        .EN_JUMP  (EN_JUMP),
        .EN_UPPER (EN_UPPER)
    ) u_decode (
        .op_i      (op_d),
        .valid_i   (valid_d),
        .ctrl_o    (dec_ctrl),
        .illegal_o (illegal_d)
    );

    assign idex_load = ~flush_e & ~hold_e;

    always_comb begin
        ctrl_e_d    = ctrl_e_q;
        valid_e_d   = valid_e_q;
        illegal_e_d = illegal_e_q;
        if (flush_e) begin
            ctrl_e_d    = '0;
            valid_e_d   = 1'b0;
            illegal_e_d = 1'b0;
        end else if (!hold_e) begin
            ctrl_e_d    = dec_ctrl;
            valid_e_d   = valid_d;
            illegal_e_d = illegal_d;
        end

        // A held EX stage must not also advance, so it feeds a bubble forward.
        if (flush_m || hold_e) begin
            exmem_d = '0;
        end else begin
            exmem_d.regwrite = ctrl_e_q[ALUOP_W+F_REGWRITE];
            exmem_d.link     = ctrl_e_q[ALUOP_W+F_LINK];
            exmem_d.memwrite = ctrl_e_q[ALUOP_W+F_MEMWRITE];
            exmem_d.memtoreg = ctrl_e_q[ALUOP_W+F_MEMTOREG];
            exmem_d.valid    = valid_e_q;
        end

        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.link     = exmem_q.link;
        memwb_d.memtoreg = exmem_q.memtoreg;

        cnt_d = cnt_q;
        if (illegal_d && idex_load && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_e_q    <= '0;
            valid_e_q   <= 1'b0;
            illegal_e_q <= 1'b0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            cnt_q       <= '0;
        end else begin
            ctrl_e_q    <= ctrl_e_d;
            valid_e_q   <= valid_e_d;
            illegal_e_q <= illegal_e_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ctrl_e      = ctrl_e_q;
    assign valid_e     = valid_e_q;
    assign illegal_e   = illegal_e_q;
    assign regwrite_m  = exmem_q.regwrite;
    assign memwrite_m  = exmem_q.memwrite;
    assign memtoreg_m  = exmem_q.memtoreg;
    assign valid_m     = exmem_q.valid;
    assign regwrite_w  = memwb_q.regwrite;
    assign memtoreg_w  = memwb_q.memtoreg;
    assign link_w      = memwb_q.link;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: a full-featured instance and a reduced one (no jump or
// upper classes, 3-bit aluop, 2-bit counter) share stimulus and a reference model.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op_d = '0;
    logic       valid_d = 1'b0;
    logic       hold_e = 1'b0;
    logic       flush_e = 1'b0;
    logic       flush_m = 1'b0;

    logic        a_illegal_d, a_valid_e, a_illegal_e, a_regwrite_m, a_memwrite_m;
    logic        a_memtoreg_m, a_valid_m, a_regwrite_w, a_memtoreg_w, a_link_w;
    logic [10:0] a_ctrl_e;
    logic [7:0]  a_illegal_cnt;

    logic        b_illegal_d, b_valid_e, b_illegal_e, b_regwrite_m, b_memwrite_m;
    logic        b_memtoreg_m, b_valid_m, b_regwrite_w, b_memtoreg_w, b_link_w;
    logic [11:0] b_ctrl_e;
    logic [1:0]  b_illegal_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.ALUOP_W(2), .EN_JUMP(1'b1), .EN_UPPER(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .op_d(op_d), .valid_d(valid_d),
        .hold_e(hold_e), .flush_e(flush_e), .flush_m(flush_m),
        .illegal_d(a_illegal_d), .ctrl_e(a_ctrl_e), .valid_e(a_valid_e),
        .illegal_e(a_illegal_e), .regwrite_m(a_regwrite_m), .memwrite_m(a_memwrite_m),
        .memtoreg_m(a_memtoreg_m), .valid_m(a_valid_m), .regwrite_w(a_regwrite_w),
        .memtoreg_w(a_memtoreg_w), .link_w(a_link_w), .illegal_cnt(a_illegal_cnt)
    );

    ctrl_pipe #(.ALUOP_W(3), .EN_JUMP(1'b0), .EN_UPPER(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .op_d(op_d), .valid_d(valid_d),
        .hold_e(hold_e), .flush_e(flush_e), .flush_m(flush_m),
        .illegal_d(b_illegal_d), .ctrl_e(b_ctrl_e), .valid_e(b_valid_e),
        .illegal_e(b_illegal_e), .regwrite_m(b_regwrite_m), .memwrite_m(b_memwrite_m),
        .memtoreg_m(b_memtoreg_m), .valid_m(b_valid_m), .regwrite_w(b_regwrite_w),
        .memtoreg_w(b_memtoreg_w), .link_w(b_link_w), .illegal_cnt(b_illegal_cnt)
    );

    // Reference model: per configuration, one record per pipeline stage.
    int  cfg_aw  [2] = '{2, 3};
    bit  cfg_ej  [2] = '{1'b1, 1'b0};
    bit  cfg_eu  [2] = '{1'b1, 1'b0};
    int  cfg_max [2] = '{255, 3};

    logic [11:0] e_ctrl [2];
    bit          e_v    [2];
    bit          e_il   [2];
    logic [11:0] m_ctrl [2];
    bit          m_v    [2];
    logic [11:0] w_ctrl [2];
    int          cnt    [2];

    logic [6:0] op_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                               7'b0010111};

    // Flags listed regwrite,link,alusrc,asel_pc,branch,jump,jalr,memwrite,memtoreg.
    function automatic logic [11:0] mdl_bundle(input logic [6:0] op, input logic v,
                                                input int c, output bit ill);
        int  f = 0;
        int  a = 0;
        bit  ok = 1'b1;
        case (op)
            7'b0110011: begin f = 'b100000000; a = 2; end
            7'b0010011: begin f = 'b101000000; a = 2; end
            7'b0000011: begin f = 'b101000001; a = 0; end
            7'b0100011: begin f = 'b001000010; a = 0; end
            7'b1100011: begin f = 'b000010000; a = 1; end
            7'b1101111: begin f = 'b110001000; a = 0; ok = cfg_ej[c]; end
            7'b1100111: begin f = 'b111001100; a = 0; ok = cfg_ej[c]; end
            7'b0110111: begin f = 'b101000000; a = 3; ok = cfg_eu[c]; end
            7'b0010111: begin f = 'b101100000; a = 0; ok = cfg_eu[c]; end
            default:    ok = 1'b0;
        endcase
        ill = v && !ok;
        if (v && ok) return 12'((f << cfg_aw[c]) | a);
        return '0;
    endfunction

    function automatic logic fbit(input logic [11:0] ctrl, input int c, input int k);
        return ctrl[cfg_aw[c] + k];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clock();
        bit ill;
        logic [11:0] dec;
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                e_ctrl[c] = '0; e_v[c] = 0; e_il[c] = 0;
                m_ctrl[c] = '0; m_v[c] = 0; w_ctrl[c] = '0; cnt[c] = 0;
            end else begin
                w_ctrl[c] = m_ctrl[c];
                if (flush_m || hold_e) begin
                    m_ctrl[c] = '0; m_v[c] = 0;
                end else begin
                    m_ctrl[c] = e_ctrl[c]; m_v[c] = e_v[c];
                end
                if (flush_e) begin
                    e_ctrl[c] = '0; e_v[c] = 0; e_il[c] = 0;
                end else if (!hold_e) begin
                    dec = mdl_bundle(op_d, valid_d, c, ill);
                    e_ctrl[c] = dec; e_v[c] = valid_d; e_il[c] = ill;
                    if (ill && cnt[c] < cfg_max[c]) cnt[c]++;
                end
            end
        end
    endtask

    task automatic check_stages();
        check("A ctrl_e",      a_ctrl_e,      e_ctrl[0]);
        check("A valid_e",     a_valid_e,     e_v[0]);
        check("A illegal_e",   a_illegal_e,   e_il[0]);
        check("A regwrite_m",  a_regwrite_m,  fbit(m_ctrl[0], 0, 8));
        check("A memwrite_m",  a_memwrite_m,  fbit(m_ctrl[0], 0, 1));
        check("A memtoreg_m",  a_memtoreg_m,  fbit(m_ctrl[0], 0, 0));
        check("A valid_m",     a_valid_m,     m_v[0]);
        check("A regwrite_w",  a_regwrite_w,  fbit(w_ctrl[0], 0, 8));
        check("A memtoreg_w",  a_memtoreg_w,  fbit(w_ctrl[0], 0, 0));
        check("A link_w",      a_link_w,      fbit(w_ctrl[0], 0, 7));
        check("A illegal_cnt", a_illegal_cnt, cnt[0]);
        check("B ctrl_e",      b_ctrl_e,      e_ctrl[1]);
        check("B valid_e",     b_valid_e,     e_v[1]);
        check("B illegal_e",   b_illegal_e,   e_il[1]);
        check("B regwrite_m",  b_regwrite_m,  fbit(m_ctrl[1], 1, 8));
        check("B memwrite_m",  b_memwrite_m,  fbit(m_ctrl[1], 1, 1));
        check("B memtoreg_m",  b_memtoreg_m,  fbit(m_ctrl[1], 1, 0));
        check("B valid_m",     b_valid_m,     m_v[1]);
        check("B regwrite_w",  b_regwrite_w,  fbit(w_ctrl[1], 1, 8));
        check("B memtoreg_w",  b_memtoreg_w,  fbit(w_ctrl[1], 1, 0));
        check("B link_w",      b_link_w,      fbit(w_ctrl[1], 1, 7));
        check("B illegal_cnt", b_illegal_cnt, cnt[1]);
    endtask

    task automatic step(input logic [6:0] op, input logic v, input logic he,
                        input logic fe, input logic fm, input logic rst);
        bit ill;
        logic [11:0] unused_dec;
        @(negedge clk);
        op_d = op; valid_d = v; hold_e = he; flush_e = fe; flush_m = fm; reset = rst;
        #1;
        unused_dec = mdl_bundle(op, v, 0, ill);
        check("A illegal_d", a_illegal_d, ill);
        unused_dec = mdl_bundle(op, v, 1, ill);
        check("B illegal_d", b_illegal_d, ill);
        @(posedge clk);
        model_clock();
        #1;
        check_stages();
    endtask

    initial begin
        logic [6:0] rop;
        int r;

        step(7'h00, 0, 0, 0, 0, 1);
        step(7'h00, 0, 0, 0, 0, 1);

        // Every opcode class in order, then drain.
        for (int i = 0; i < 9; i++) step(op_tab[i], 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(7'h00, 0, 0, 0, 0, 0);

        // Load held in EX for two cycles.
        step(7'b0000011, 1, 0, 0, 0, 0);
        step(7'b0110011, 1, 1, 0, 0, 0);
        step(7'b0110011, 1, 1, 0, 0, 0);
        step(7'b0110011, 1, 0, 0, 0, 0);

        // Flush overriding hold with an illegal op in ID.
        step(7'b1111111, 1, 1, 1, 0, 0);
        step(7'h00, 0, 0, 0, 1, 0);

        // Counter saturation on the reduced instance: JAL is illegal there.
        step(7'h00, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(7'b1101111, 1, 0, 0, 0, 0);
        check("B cnt saturated", b_illegal_cnt, 2'd3);
        check("A cnt untouched", a_illegal_cnt, 8'd0);

        // Stores in flight, then a single-cycle reset.
        for (int i = 0; i < 4; i++) step(7'b0100011, 1, 0, 0, 0, 0);
        step(7'b0110011, 1, 0, 0, 0, 1);
        step(7'b0110011, 1, 0, 0, 0, 0);
        step(7'h00, 0, 0, 0, 0, 0);
        step(7'h00, 0, 0, 0, 0, 0);
        check("A R reaches WB", a_regwrite_w, 1'b1);

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 15);
            rop = (r < 12) ? op_tab[r % 9] : 7'($urandom);
            step(rop, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
